// File: rtl/bcd2_seg7_scan_if.sv
// Display bus for bcd2_seg7_scan.
// Inputs to the scanner: BCD_In (packed BCD), LZB_En (leading-zero blank),
// DP_In (decimal point requests).
// Outputs from the scanner: Seg_Out (a..g), Dp_Out, Dig_Out (digit enables),
// Frame_Start (snapshot pulse).
// master = the side driving the BCD value, slave = the scanner.
interface bcd2_seg7_scan_if;
    logic [7:0] BCD_In;
    logic       LZB_En;
    logic [1:0] DP_In;
    logic [6:0] Seg_Out;
    logic       Dp_Out;
    logic [1:0] Dig_Out;
    logic       Frame_Start;

    modport master (
        output BCD_In, LZB_En, DP_In,
        input  Seg_Out, Dp_Out, Dig_Out, Frame_Start
    );

    modport slave (
        input  BCD_In, LZB_En, DP_In,
        output Seg_Out, Dp_Out, Dig_Out, Frame_Start
    );
endinterface

// File: rtl/bcd2_seg7_scan.sv
// Two-digit multiplexed 7-segment scanner for a packed-BCD 00-23 hour value.
// Each frame: BLANK_L, SHOW_L (units), BLANK_H, SHOW_H (tens). The input is
// snapshotted once per frame on the edge entering BLANK_L so the display never
// tears. Blank slots between digits suppress ghosting.
// Ports:
//   CLK   - system clock
//   RSTn  - asynchronous active-low reset
//   bus   - slave side of bcd2_seg7_scan_if (BCD_In, LZB_En, DP_In in;
//           Seg_Out, Dp_Out, Dig_Out, Frame_Start out, all registered)
module bcd2_seg7_scan #(
    parameter int unsigned SCAN_DIV    = 50_000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTn,
    bcd2_seg7_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] BLANK_RLD = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_RLD  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);

    localparam logic [1:0] BLANK_L = 2'd0;
    localparam logic [1:0] SHOW_L  = 2'd1;
    localparam logic [1:0] BLANK_H = 2'd2;
    localparam logic [1:0] SHOW_H  = 2'd3;

    localparam logic [6:0] SEG_INV = {7{SEG_ACT_LOW}};
    localparam logic [1:0] DIG_INV = {2{DIG_ACT_LOW}};

    // Active-high segment pattern, bit6..0 = g..a; non-BCD shows a dash.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h40;
        endcase
    endfunction

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             started;
    logic [7:0]       snap_bcd;
    logic [1:0]       snap_dp;
    logic             enter_frame;

    logic [6:0]       seg_q, seg_nxt;
    logic             dp_q, dp_nxt;
    logic [1:0]       dig_q, dig_nxt;
    logic             fs_q;

    logic [6:0]       seg_hi;
    logic             dp_hi;
    logic [1:0]       dig_hi;

    // Next state, slot counter and output decode of the state being entered.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt - CNT_W'(1);
        enter_frame = 1'b0;
        seg_hi      = 7'h00;
        dp_hi       = 1'b0;
        dig_hi      = 2'b00;

        // The first edge after reset opens a fresh, full-length BLANK_L.
        if (!started) begin
            state_nxt   = BLANK_L;
            cnt_nxt     = BLANK_RLD;
            enter_frame = 1'b1;
        end else if (cnt == '0) begin
            case (state)
                BLANK_L: begin
                    state_nxt = SHOW_L;
                    cnt_nxt   = SHOW_RLD;
                end
                SHOW_L: begin
                    state_nxt = BLANK_H;
                    cnt_nxt   = BLANK_RLD;
                end
                BLANK_H: begin
                    state_nxt = SHOW_H;
                    cnt_nxt   = SHOW_RLD;
                end
                default: begin
                    state_nxt   = BLANK_L;
                    cnt_nxt     = BLANK_RLD;
                    enter_frame = 1'b1;
                end
            endcase
        end

        // Snapshot never changes on an edge entering a SHOW state.
        case (state_nxt)
            SHOW_L: begin
                dig_hi = 2'b01;
                seg_hi = seg7(snap_bcd[3:0]);
                dp_hi  = snap_dp[0];
            end
            SHOW_H: begin
                if (!(bus.LZB_En && (snap_bcd[7:4] == 4'd0))) begin
                    dig_hi = 2'b10;
                    seg_hi = seg7(snap_bcd[7:4]);
                    dp_hi  = snap_dp[1];
                end
            end
            default: begin
            end
        endcase

        seg_nxt = seg_hi ^ SEG_INV;
        dp_nxt  = dp_hi ^ SEG_ACT_LOW;
        dig_nxt = dig_hi ^ DIG_INV;
    end

    // State, counter, snapshot and registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= BLANK_L;
            cnt      <= BLANK_RLD;
            started  <= 1'b0;
            snap_bcd <= 8'h00;
            snap_dp  <= 2'b00;
            seg_q    <= SEG_INV;
            dp_q     <= SEG_ACT_LOW;
            dig_q    <= DIG_INV;
            fs_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            started <= 1'b1;
            if (enter_frame) begin
                snap_bcd <= bus.BCD_In;
                snap_dp  <= bus.DP_In;
            end
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
            dig_q <= dig_nxt;
            fs_q  <= enter_frame;
        end
    end

    assign bus.Seg_Out     = seg_q;
    assign bus.Dp_Out      = dp_q;
    assign bus.Dig_Out     = dig_q;
    assign bus.Frame_Start = fs_q;

endmodule

// File: tb/tb_bcd2_seg7_scan.sv
// Self-checking bench for bcd2_seg7_scan (SCAN_DIV=10, BLANK_CYC=2, active-low).
// A frame-phase model predicts the outputs after every clock edge and queues
// them; a negedge checker pops and compares against the DUT.
module tb_bcd2_seg7_scan;

    localparam int unsigned SCAN_DIV  = 10;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = 2 * SCAN_DIV;
    // {Frame_Start, Dig_Out[1:0], Dp_Out, Seg_Out[6:0]}
    localparam logic [10:0] INACT = {1'b0, 2'b11, 1'b1, 7'h7F};

    logic CLK;
    logic RSTn;

    bcd2_seg7_scan_if bus ();

    bcd2_seg7_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [10:0] exp_q[$];

    bit          m_started = 1'b0;
    int          m_t       = 0;
    logic [7:0]  m_snap    = 8'h00;
    logic [1:0]  m_sdp     = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B;
            4'h3: dec = 7'h4F; 4'h4: dec = 7'h66; 4'h5: dec = 7'h6D;
            4'h6: dec = 7'h7D; 4'h7: dec = 7'h07; 4'h8: dec = 7'h7F;
            4'h9: dec = 7'h6F;
            default: dec = 7'h40;
        endcase
    endfunction

    function automatic logic [10:0] outs_now();
        return {bus.Frame_Start, bus.Dig_Out, bus.Dp_Out, bus.Seg_Out};
    endfunction

    // Reference model: phase within the frame counted from the first edge after reset.
    initial begin
        int          p;
        logic [10:0] e;
        forever begin
            @(posedge CLK);
            if (!RSTn) begin
                m_started = 1'b0;
            end else begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_t       = 0;
                end else begin
                    m_t++;
                end
                p = m_t % FRAME;
                if (p == 0) begin
                    m_snap = bus.BCD_In;
                    m_sdp  = bus.DP_In;
                end
                e = INACT;
                e[10] = (p == 0);
                if (p >= BLANK_CYC && p < SCAN_DIV) begin
                    e[9:8] = 2'b10;
                    e[7]   = ~m_sdp[0];
                    e[6:0] = ~dec(m_snap[3:0]);
                end else if (p >= SCAN_DIV + BLANK_CYC) begin
                    if (!(bus.LZB_En && m_snap[7:4] == 4'h0)) begin
                        e[9:8] = 2'b01;
                        e[7]   = ~m_sdp[1];
                        e[6:0] = ~dec(m_snap[7:4]);
                    end
                end
                exp_q.push_back(e);
            end
        end
    end

    // Checker: inactive outputs while in reset, otherwise the queued prediction.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                check("rst_hold", 32'(outs_now()), 32'(INACT));
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scan_out", 32'(outs_now()), 32'(e));
                check("dig_onehot", 32'(bus.Dig_Out == 2'b00), 32'(0));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_phase(input int ph);
        bit found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge CLK);
            if (m_started && (m_t % FRAME) == ph) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_phase", 32'(found), 32'(1));
    endtask

    initial begin
        RSTn       = 1'b0;
        bus.BCD_In = 8'h23;
        bus.LZB_En = 1'b0;
        bus.DP_In  = 2'b00;

        run(4);
        RSTn = 1'b1;
        run(2 * FRAME);

        bus.BCD_In = 8'h05;
        bus.LZB_En = 1'b1;
        run(2 * FRAME);
        bus.LZB_En = 1'b0;
        run(2 * FRAME);

        bus.BCD_In = 8'hA3;
        bus.DP_In  = 2'b10;
        run(2 * FRAME);

        bus.BCD_In = 8'h23;
        bus.DP_In  = 2'b00;
        run(FRAME);
        wait_phase(5);
        bus.BCD_In = 8'h00;
        run(2 * FRAME);

        // Asynchronous reset in the middle of a SHOW_H slot.
        bus.BCD_In = 8'h17;
        run(FRAME);
        wait_phase(15);
        check("pre_rst_tens_on", 32'(bus.Dig_Out), 32'(2'b01));
        @(posedge CLK);
        #2;
        RSTn = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst", 32'(outs_now()), 32'(INACT));
        run(3);
        RSTn = 1'b1;
        run(2 * FRAME);

        for (int k = 0; k < 8; k++) begin
            bus.BCD_In = 8'($urandom);
            bus.LZB_En = 1'($urandom);
            bus.DP_In  = 2'($urandom);
            run(int'($urandom_range(1, 30)));
        end
        run(FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
